imm_decode_stage: RTL
=====================

Name:
imm_decode_stage

Overview:
- Registered instruction-decode front stage.
- Accepts 32-bit RISC-V instruction words with their PCs over a valid/ready handshake.
- Classifies each word's format and produces the sign-extended immediate at XLEN width.
- Presents results downstream through a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Sits between the fetch queue and the register-read stage; successor to the single-cycle combinational immediate extractor.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN. The OP-IMM-32 and OP-32 opcodes are legal only when XLEN=64.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all buffered entries
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept; driven from a register
- in_insn  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head
- out_insn  out  32  head instruction word
- out_pc  out  XLEN  head PC
- out_imm  out  XLEN  head immediate, sign-extended
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- out_illegal  out  1  head opcode is unrecognised

Behaviour:
- Reset (async assert, sync deassert): state=EMPTY; out_valid=0; in_ready=1; out_insn, out_pc and out_imm = 0; out_fmt=7; out_illegal=0.
- Decode is combinational on in_insn and is captured at acceptance (in_valid & in_ready). Buffered entries never re-decode.
- Opcode to format mapping:
  - 0110011 → R; 0111011 → R (XLEN=64 only)
  - 0000011, 0010011, 1100111, 0001111, 1110011 → I; 0011011 → I (XLEN=64 only)
  - 0100011 → S; 1100011 → B
  - 0110111, 0010111 → U; 1101111 → J
  - anything else → fmt 7, out_illegal=1, imm=0
- Immediate construction:
  - I: insn[31:20]
  - S: {insn[31:25], insn[11:7]}
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 0}
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 0}
  - U: {insn[31:12], 12'b0}
  - All of the above sign-extended from bit 31 of the insn to XLEN; R: imm=0.
- Storage: main entry M (drives the out_* ports) and skid entry K.
- State machine, with acc = in_valid & in_ready and deq = out_valid & out_ready:
  - EMPTY: on acc, new → M, go to ONE.
  - ONE: on acc & deq, new → M, stay. On acc & !deq, new → K, go to TWO. On !acc & deq, go to EMPTY.
  - TWO: in_ready=0. On deq, K → M, go to ONE.
- in_ready = (state != TWO), registered.
- Latency: accept at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Ordering is strictly FIFO.
- Stall: out_valid stays high and all out_* fields stay stable while out_ready=0.
- flush:
  - Has priority: at the next edge, state → EMPTY and in_ready → 1.
  - An input handshake in the flush cycle is discarded.
  - A deq in the flush cycle still counts as consumed by downstream.
- Reset mid-operation drops all entries immediately (asynchronous).

Optional Feature:
- IMM_DECODE_ZICSR_EN
- Defined:
  - SYSTEM opcode with funct3 ∈ {101, 110, 111} (CSRRWI/CSRRSI/CSRRCI) produces imm = zero-extended insn[19:15] (zimm) and fmt=1.
  - Adds output port out_csr (12 bits) = insn[31:20] of the head entry for all SYSTEM instructions, 0 otherwise.
- Undefined:
  - SYSTEM is decoded as plain I-type with a sign-extended imm.
  - out_csr is absent.

Test Plan:
- XLEN=32, single word 0x14d28393 with out_ready=1 → one cycle later out_valid=1, fmt=1, imm=333; 0xfd634f93 → imm=0xFFFFFFD6.
- Back-to-back stream: 0x3e831363, 0x9841cae3, 0xff1ff4ef, 0xff806237 → imm 998, -1644, -16, 0xFF806000 in order, with fmts 3, 3, 5, 4.
- out_ready=0, push 3 words → first two accepted, in_ready=0 from the cycle after the second accept; then raise out_ready → drain in order, in_ready=1 after the first deq.
- TWO state with flush=1 and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, the flush-cycle word is absent.
- XLEN=64: 0xb2fff7ef → imm=0xFFFFFFFFFFFFFB2E. Opcode 0011011 with XLEN=32 → fmt=7, out_illegal=1, imm=0. Word 0x00000000 → illegal.
- With IMM_DECODE_ZICSR_EN: csrrwi x1, 0x305, 17 (0x3058d0f3) → imm=17, out_csr=0x305. Without the macro → imm=0x305.

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for imm_decode_stage: upstream words in, decoded head entry out.
// out_csr is present only when IMM_DECODE_ZICSR_EN is defined.
interface imm_decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_insn;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
`ifdef IMM_DECODE_ZICSR_EN
    logic [11:0]     out_csr;

    modport master (
        output flush, in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_insn, out_pc, out_imm, out_fmt, out_illegal, out_csr
    );
    modport slave (
        input  flush, in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_insn, out_pc, out_imm, out_fmt, out_illegal, out_csr
    );
`else
    modport master (
        output flush, in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_insn, out_pc, out_imm, out_fmt, out_illegal
    );
    modport slave (
        input  flush, in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_insn, out_pc, out_imm, out_fmt, out_illegal
    );
`endif
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RISC-V immediate decode stage with a 2-entry skid buffer (main M, skid K).
// Optional macro IMM_DECODE_ZICSR_EN: CSR zimm immediates and the out_csr field.
module imm_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input logic               clk,
    input logic               rst_n,
    imm_decode_stage_if.slave bus
);
    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
`ifdef IMM_DECODE_ZICSR_EN
        logic [11:0]     csr;
`endif
    } entry_t;

    state_e      r_state;
    state_e      w_state_d;
    logic        r_in_ready;
    entry_t      r_m;
    entry_t      r_k;
    entry_t      w_dec;
    logic [6:0]  w_opcode;
    logic [2:0]  w_fmt;
    logic [31:0] w_imm32;
    logic        w_acc;
    logic        w_deq;
    logic        w_load_m_new;
    logic        w_load_m_k;
    logic        w_load_k;

    assign w_opcode = bus.in_insn[6:0];

    always_comb begin
        w_fmt = FmtIll;
        case (w_opcode)
            7'b0110011: w_fmt = FmtR;
            7'b0111011: w_fmt = (XLEN == 64) ? FmtR : FmtIll;
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: w_fmt = FmtI;
            7'b0011011: w_fmt = (XLEN == 64) ? FmtI : FmtIll;
            7'b0100011: w_fmt = FmtS;
            7'b1100011: w_fmt = FmtB;
            7'b0110111, 7'b0010111: w_fmt = FmtU;
            7'b1101111: w_fmt = FmtJ;
            default: w_fmt = FmtIll;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FmtI: w_imm32 = {{20{bus.in_insn[31]}}, bus.in_insn[31:20]};
            FmtS: w_imm32 = {{20{bus.in_insn[31]}}, bus.in_insn[31:25], bus.in_insn[11:7]};
            FmtB: w_imm32 = {{19{bus.in_insn[31]}}, bus.in_insn[31], bus.in_insn[7],
                             bus.in_insn[30:25], bus.in_insn[11:8], 1'b0};
            FmtU: w_imm32 = {bus.in_insn[31:12], 12'b0};
            FmtJ: w_imm32 = {{11{bus.in_insn[31]}}, bus.in_insn[31], bus.in_insn[19:12],
                             bus.in_insn[20], bus.in_insn[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    always_comb begin
        w_dec.insn    = bus.in_insn;
        w_dec.pc      = bus.in_pc;
        w_dec.fmt     = w_fmt;
        w_dec.illegal = (w_fmt == FmtIll);
        w_dec.imm     = XLEN'($signed(w_imm32));
`ifdef IMM_DECODE_ZICSR_EN
        w_dec.csr = '0;
        if (w_opcode == OpSystem) begin
            w_dec.csr = bus.in_insn[31:20];
            // funct3 101/110/111: immediate-operand CSR ops carry a 5-bit zimm
            if (bus.in_insn[14] && (bus.in_insn[13] || bus.in_insn[12])) begin
                w_dec.imm = XLEN'(bus.in_insn[19:15]);
            end
        end
`endif
    end

    assign w_acc = bus.in_valid & r_in_ready;
    assign w_deq = bus.out_valid & bus.out_ready;

    always_comb begin
        w_state_d    = r_state;
        w_load_m_new = 1'b0;
        w_load_m_k   = 1'b0;
        w_load_k     = 1'b0;
        if (bus.flush) begin
            w_state_d = StEmpty;
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_acc) begin
                        w_load_m_new = 1'b1;
                        w_state_d    = StOne;
                    end
                end
                StOne: begin
                    if (w_acc && w_deq) begin
                        w_load_m_new = 1'b1;
                    end else if (w_acc) begin
                        w_load_k  = 1'b1;
                        w_state_d = StTwo;
                    end else if (w_deq) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (w_deq) begin
                        w_load_m_k = 1'b1;
                        w_state_d  = StOne;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
            r_m        <= '0;
            r_m.fmt    <= FmtIll;
            r_k        <= '0;
            r_k.fmt    <= FmtIll;
        end else begin
            r_state    <= w_state_d;
            r_in_ready <= (w_state_d != StTwo);
            if (w_load_m_new) begin
                r_m <= w_dec;
            end else if (w_load_m_k) begin
                r_m <= r_k;
            end
            if (w_load_k) begin
                r_k <= w_dec;
            end
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = (r_state != StEmpty);
    assign bus.out_insn    = r_m.insn;
    assign bus.out_pc      = r_m.pc;
    assign bus.out_imm     = r_m.imm;
    assign bus.out_fmt     = r_m.fmt;
    assign bus.out_illegal = r_m.illegal;
`ifdef IMM_DECODE_ZICSR_EN
    assign bus.out_csr     = r_m.csr;
`endif
endmodule
